redundant_alu_exec: RTL
=======================

// Module: redundant_alu_exec
// PURPOSE
//  Parametrised time-redundant execute unit with spare-ALU switchover for the 5-stage RV32 pipeline.
//  - Replaces the fixed 2-state redundant ALU in execute_cycle.
//  - Runs each op NUM_RUNS times, votes or compares, retries uncorrectable ops and counts consecutive faults.
//  - After FAULT_THRESH faulty ops it permanently switches to the spare ALU.
//  - Drives the busy stall consumed by hazard_unit and the hardware fault flag.
// PARAMETERS
//  XLEN          32  operand/result width
//  NUM_RUNS      3   executions per op; legal 2 (compare) or 3 (bitwise majority)
//  MAX_RETRY     1   re-executions of a whole run set when uncorrectable
//  FAULT_THRESH  4   consecutive faulty ops before spare switchover (>=1)
//  CROSS_CHECK   1   1: last run of each set executes on spare ALU; 0: all runs on active ALU
// PORTS
//  clk             in   1     clock
//  rst             in   1     synchronous active-high reset
//  start           in   1     op request; accepted in IDLE or DONE
//  flush           in   1     abort in-flight op
//  alu_ctrl        in   3     000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed), 110 sll, 111 srl
//  op_a, op_b      in   XLEN  operands; sampled only on accepted start
//  fault_inj_en    in   1     test hook: XOR fault_inj_mask into primary ALU output
//  fault_inj_mask  in   XLEN  injection mask
//  busy            out  1     stall request to hazard_unit
//  result_valid    out  1     one-cycle pulse, result/zero/result_err valid
//  result          out  XLEN  voted result
//  zero            out  1     result == 0
//  result_err      out  1     uncorrectable after retries (with result_valid)
//  fault_detected  out  1     any run mismatch in completed op (with result_valid)
//  spare_active    out  1     sticky; spare ALU is the active ALU
//  fault_count     out  $clog2(FAULT_THRESH+1)  consecutive faulty ops, saturating
// BEHAVIOUR
//  - Clock: one clock, clk. Reset: rst is synchronous and active-high.
//  - Reset: state=IDLE; all outputs 0; run and retry counters 0; spare_active=0.
//  - FSM states and transitions:
//    - IDLE -start-> RUN.
//    - RUN holds for NUM_RUNS cycles; run k captures ALU output into slot k.
//    - RUN -> VOTE for 1 cycle -> DONE, or VOTE -> RUN when a retry is taken.
//    - DONE lasts 1 cycle. DONE -start-> RUN (back-to-back); otherwise DONE -> IDLE.
//  - Handshake:
//    - busy = start accepted this cycle, OR state in {RUN, VOTE}. busy is combinational, so the stall asserts in the issue cycle.
//    - busy is low in IDLE/DONE unless start is asserted.
//  - Latency: start accepted at edge t gives result_valid at t+NUM_RUNS+2, plus (NUM_RUNS+1) cycles per retry.
//  - ALU selection per run:
//    - spare_active=1: all runs use spare.
//    - Else CROSS_CHECK=1: run NUM_RUNS-1 uses spare, the rest use primary.
//    - Else all runs use primary.
//    - Injection affects the primary only, every cycle fault_inj_en=1.
//  - Vote, NUM_RUNS=2:
//    - mismatch = slot0!=slot1; result=slot0.
//    - Uncorrectable = mismatch.
//  - Vote, NUM_RUNS=3:
//    - result = bitwise maj(s0,s1,s2); mismatch = any pair differs.
//    - Uncorrectable = all three pairwise different.
//  - Retry: uncorrectable with retry_cnt<MAX_RETRY -> retry_cnt++, re-run the full set on the same latched operands.
//  - Op completion (DONE):
//    - result_err = still uncorrectable.
//    - fault_detected = mismatch seen on any attempt.
//  - fault_count:
//    - +1 (saturating at FAULT_THRESH) on a faulty op.
//    - Cleared on a clean op.
//    - Updated at DONE.
//  - Switchover: the DONE whose fault_count update reaches FAULT_THRESH sets spare_active. It takes effect from the next op; the current result is unchanged.
//  - Known limitation: before switchover, a permanent primary fault can win a 3-run majority. It is flagged, never silent.
//  - Arithmetic:
//    - add/sub wrap modulo 2^XLEN.
//    - Shifts use op_b[$clog2(XLEN)-1:0].
//    - slt yields 1 or 0, zero-extended.
//  - flush: in RUN/VOTE -> IDLE next cycle. No result_valid; fault_count and spare_active untouched. flush has priority over a simultaneous start.
//  - rst mid-op: immediate return to reset values, including spare_active=0.
// STRUCTURE
//  - Package redundant_alu_pkg:
//    - ALU op codes (ALU_ADD..ALU_SRL) and FSM state encoding (IDLE/RUN/VOTE/DONE).
//    - NUM_RUNS legality check function.
//  - Sub-module alu_core (XLEN): combinational ALU. Instantiated twice: u_alu_primary, u_alu_spare.
//  - Top level holds the FSM, result slots, voter, counters and injection XOR.
// TESTING
//  - Defaults, add 5+7, no injection -> result_valid at t+5, result=12, zero=0, fault_detected=0, busy high t..t+4.
//  - NUM_RUNS=3, inject mask 0x1 for run 1 only on 5+7 -> result=12, fault_detected=1, result_err=0, fault_count=1. A following clean op resets fault_count to 0.
//  - NUM_RUNS=2, MAX_RETRY=1, inject mask 0x1 on first attempt only -> retry taken, result=12 at t+7, fault_detected=1, result_err=0.
//  - NUM_RUNS=3, CROSS_CHECK=1, constant mask 0x1 for 5 ops of 5+7:
//    - Ops 1-4: fault_detected=1 and result=13.
//    - spare_active=1 after op 4's DONE.
//    - Op 5: result=12, fault_detected=0.
//  - flush asserted 2 cycles after start -> no result_valid, IDLE next cycle. Next start completes normally with unchanged fault_count.
//  - slt op_a=0xFFFFFFFF, op_b=1 -> result=1. sub 3-3 -> result=0, zero=1. Back-to-back start in DONE -> busy continuous, two result_valid pulses.

Source files
------------

// File: rtl/redundant_alu_pkg.sv
// Shared types for the time-redundant execute unit: ALU op codes, FSM states
// and the run-count legality check.
package redundant_alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    VOTE = 2'd2,
    DONE = 2'd3
  } state_e;

  // Only pairwise compare (2) and bitwise majority (3) are supported.
  function automatic bit num_runs_legal(input int n);
    return (n == 2) || (n == 3);
  endfunction

endpackage

// File: rtl/redundant_alu_exec_alu_core.sv
// Combinational RV32-style ALU; instantiated as primary and spare.
module alu_core
  import redundant_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e         alu_ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] shamt;
  assign shamt = b[SW-1:0];

  always_comb begin
    y = '0;
    unique case (alu_ctrl)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLT: y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLL: y = a << shamt;
      ALU_SRL: y = a >> shamt;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/redundant_alu_exec.sv
// Time-redundant execute unit: runs each op several times, votes, retries
// uncorrectable sets and switches to the spare ALU after repeated faults.
module redundant_alu_exec
  import redundant_alu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NUM_RUNS     = 3,
  parameter int MAX_RETRY    = 1,
  parameter int FAULT_THRESH = 4,
  parameter int CROSS_CHECK  = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              flush,
  input  logic [2:0]                        alu_ctrl,
  input  logic [XLEN-1:0]                   op_a,
  input  logic [XLEN-1:0]                   op_b,
  input  logic                              fault_inj_en,
  input  logic [XLEN-1:0]                   fault_inj_mask,
  output logic                              busy,
  output logic                              result_valid,
  output logic [XLEN-1:0]                   result,
  output logic                              zero,
  output logic                              result_err,
  output logic                              fault_detected,
  output logic                              spare_active,
  output logic [$clog2(FAULT_THRESH+1)-1:0] fault_count
);

  // An illegal run count falls back to majority voting.
  localparam int RUNS = num_runs_legal(NUM_RUNS) ? NUM_RUNS : 3;
  localparam int RCW  = $clog2(RUNS);
  localparam int RTW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int FCW  = $clog2(FAULT_THRESH + 1);

  typedef struct packed {
    alu_op_e         op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } req_t;

  state_e                     state, state_nx;
  req_t                       req;
  logic [RUNS-1:0][XLEN-1:0]  slot;
  logic [RCW-1:0]             run_cnt;
  logic [RTW-1:0]             retry_cnt;
  logic                       fault_seen;

  logic [XLEN-1:0] y_pri, y_spa, y_pri_inj, alu_y, vote_y;
  logic            accept, last_run, use_spare, mism, uncorr, retry_take;
  logic [FCW-1:0]  fc_inc;

  alu_core #(.XLEN(XLEN)) u_alu_primary (.alu_ctrl(req.op), .a(req.a), .b(req.b), .y(y_pri));
  alu_core #(.XLEN(XLEN)) u_alu_spare   (.alu_ctrl(req.op), .a(req.a), .b(req.b), .y(y_spa));

  assign y_pri_inj = y_pri ^ (fault_inj_en ? fault_inj_mask : '0);
  assign last_run  = (run_cnt == RCW'(RUNS - 1));
  // Cross-check puts the final run of each set on the spare so a common-mode
  // primary fault still shows up as a mismatch.
  assign use_spare = spare_active || ((CROSS_CHECK != 0) && last_run);
  assign alu_y     = use_spare ? y_spa : y_pri_inj;

  if (RUNS == 2) begin : g_cmp
    assign vote_y = slot[0];
    assign mism   = (slot[0] != slot[1]);
    assign uncorr = mism;
  end else begin : g_maj
    logic d01, d02, d12;
    assign d01    = (slot[0] != slot[1]);
    assign d02    = (slot[0] != slot[2]);
    assign d12    = (slot[1] != slot[2]);
    assign vote_y = (slot[0] & slot[1]) | (slot[0] & slot[2]) | (slot[1] & slot[2]);
    assign mism   = d01 | d02 | d12;
    assign uncorr = d01 & d02 & d12;
  end

  assign retry_take   = uncorr && (retry_cnt < RTW'(MAX_RETRY));
  assign accept       = start && !flush && ((state == IDLE) || (state == DONE));
  assign busy         = accept || (state == RUN) || (state == VOTE);
  assign result_valid = (state == DONE);
  assign fc_inc       = (fault_count == FCW'(FAULT_THRESH)) ? fault_count : fault_count + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (flush) state_nx = IDLE;
               else if (last_run) state_nx = VOTE;
      VOTE:    if (flush) state_nx = IDLE;
               else if (retry_take) state_nx = RUN;
               else state_nx = DONE;
      DONE:    state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req            <= '0;
      slot           <= '0;
      run_cnt        <= '0;
      retry_cnt      <= '0;
      fault_seen     <= 1'b0;
      result         <= '0;
      zero           <= 1'b0;
      result_err     <= 1'b0;
      fault_detected <= 1'b0;
      fault_count    <= '0;
      spare_active   <= 1'b0;
    end else begin
      if (accept) begin
        req        <= '{op: alu_op_e'(alu_ctrl), a: op_a, b: op_b};
        run_cnt    <= '0;
        retry_cnt  <= '0;
        fault_seen <= 1'b0;
      end
      if ((state == RUN) && !flush) begin
        slot[run_cnt] <= alu_y;
        run_cnt       <= last_run ? '0 : run_cnt + 1'b1;
      end
      if ((state == VOTE) && !flush) begin
        if (retry_take) begin
          retry_cnt  <= retry_cnt + 1'b1;
          fault_seen <= 1'b1;
        end else begin
          result         <= vote_y;
          zero           <= (vote_y == '0);
          result_err     <= uncorr;
          fault_detected <= fault_seen | mism;
          // Spare takes over from the next op; this op's result stands.
          if (fault_seen | mism) begin
            fault_count <= fc_inc;
            if (fc_inc == FCW'(FAULT_THRESH)) spare_active <= 1'b1;
          end else begin
            fault_count <= '0;
          end
        end
      end
    end
  end

endmodule
